// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer: aligned accesses pass through; misaligned h/w become byte sequences.
// Optional LSU_MISALIGN_TRAP_EN: raise a one-cycle misalignment trap instead of splitting.
module lsu_misalign_seq #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iValid,
    input  logic                  iMemRead,
    input  logic                  iMemWrite,
    input  logic [2:0]            iFunct3,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic [31:0]           iWriteData,
    input  logic [31:0]           iMemReadData,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    output logic [31:0]           oMemWriteData,
    output logic [2:0]            oMemFunct3,
    output logic                  oMemRead,
    output logic                  oMemWrite,
    output logic [31:0]           oLoadData,
    output logic                  oStall,
    output logic                  oMisaligned
);

    typedef enum logic [1:0] {IDLE, BYTES, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  st_q, st_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           asm_q, asm_d;

    logic mis;
    logic last;
    logic [7:0] wbyte;

    assign mis = ((iFunct3[1:0] == 2'b01) && iAddress[0])
              || ((iFunct3 == 3'b010) && (iAddress[1:0] != 2'b00));
    assign last = (f3_q[1:0] == 2'b01) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
    assign wbyte = wdata_q[8*cnt_q +: 8];

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    assign oMisaligned = trap_q;
`else
    assign oMisaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_d  = 1'b0;
`endif
        oMemAddress   = iAddress;
        oMemWriteData = iWriteData;
        oMemFunct3    = iFunct3;
        oMemRead      = iValid & iMemRead & ~iMemWrite;
        oMemWrite     = iValid & iMemWrite;
        oLoadData     = iMemReadData;
        oStall        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iValid && mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    oMemRead  = 1'b0;
                    oMemWrite = 1'b0;
                    oLoadData = '0;
                    trap_d    = 1'b1;
`else
                    oMemFunct3    = iMemWrite ? 3'b000 : 3'b100;
                    oMemWriteData = {24'b0, iWriteData[7:0]};
                    oMemRead      = ~iMemWrite;
                    oMemWrite     = iMemWrite;
                    oStall        = 1'b1;
                    base_d        = iAddress;
                    wdata_d       = iWriteData;
                    f3_d          = iFunct3;
                    st_d          = iMemWrite;
                    asm_d[7:0]    = iMemReadData[7:0];
                    cnt_d         = 2'd1;
                    state_d       = BYTES;
`endif
                end
            end
            BYTES: begin
                oMemAddress   = base_q + ADDR_WIDTH'(cnt_q);
                oMemFunct3    = st_q ? 3'b000 : 3'b100;
                oMemWriteData = {24'b0, wbyte};
                oMemRead      = ~st_q;
                oMemWrite     = st_q;
                oStall        = 1'b1;
                if (!st_q) asm_d[8*cnt_q +: 8] = iMemReadData[7:0];
                cnt_d = cnt_q + 2'd1;
                if (last) state_d = DONE;
            end
            DONE: begin
                oMemRead  = 1'b0;
                oMemWrite = 1'b0;
                if (f3_q[1:0] == 2'b01)
                    oLoadData = f3_q[2] ? {16'b0, asm_q[15:0]}
                                        : {{16{asm_q[15]}}, asm_q[15:0]};
                else
                    oLoadData = asm_q;
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset kills strobes at once so a partly issued store never gets another byte.
        if (!iRstN) begin
            oMemRead  = 1'b0;
            oMemWrite = 1'b0;
            oStall    = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            base_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            st_q    <= 1'b0;
            cnt_q   <= '0;
            asm_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

endmodule
